// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the matrix-vector multiply engine.
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, LOADED, COMPUTE} state_t;

  // Index width for an n-entry structure; never below one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int xw, input int aw, input int k);
    return xw + aw + $clog2(k);
  endfunction

endpackage

// File: rtl/mvm_lane_mac.sv
// One lane multiply/accumulate: product extended per mode, summed into a running accumulator.
module mvm_lane_mac
  import mvm_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int A_W   = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    first,
  input  logic                    mode_signed,
  input  logic [X_W-1:0]          x,
  input  logic [A_W-1:0]          a,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] acc_p2;

  // Extend both operands by one bit so a single signed multiply covers both modes.
  function automatic logic signed [ACC_W-1:0] ext_prod(input logic [X_W-1:0] xv,
                                                       input logic [A_W-1:0] av,
                                                       input logic sgn);
    logic signed [X_W:0]       xs;
    logic signed [A_W:0]       as_v;
    logic signed [X_W+A_W+1:0] p;
    xs   = {sgn & xv[X_W-1], xv};
    as_v = {sgn & av[A_W-1], av};
    p    = xs * as_v;
    return ACC_W'(p);
  endfunction

  assign sum = (first ? {ACC_W{1'b0}} : acc_p2) + ext_prod(x, a, mode_signed);

  always_ff @(posedge clk) begin
    if (en) acc_p2 <= sum;
  end

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: streams X in, walks the coefficient ROM, writes one result row per K MACs.
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int K       = 4,
  parameter int ROWS    = 4,
  parameter int X_W     = 8,
  parameter int A_W     = 8,
  parameter int ACC_W   = acc_w(X_W, A_W, K)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_en,
  input  logic                         x_valid,
  input  logic [X_W-1:0]               x_data,
  output logic                         x_ready,
  output logic                         xload_done,
  input  logic                         alu_en,
  input  logic                         mode_signed,
  output logic [addr_w(ROWS*K)-1:0]    coef_addr,
  input  logic [A_W-1:0]               coef_data,
  output logic                         busy,
  output logic                         alu_done,
  input  logic                         rd_en,
  // One extra bit so out-of-range rows can be requested and answered with zero.
  input  logic [addr_w(ROWS):0]        rd_addr,
  output logic                         rd_valid,
  output logic [N_LANES*ACC_W-1:0]     rd_data
);

  localparam int CA_W  = addr_w(ROWS*K);
  localparam int ROW_W = addr_w(ROWS);
  localparam int RA_W  = ROW_W + 1;
  localparam int KW    = addr_w(K);
  localparam int LW    = addr_w(N_LANES);
  localparam int RW    = N_LANES * ACC_W;

  localparam logic [KW-1:0]    K_LAST = KW'(K - 1);
  localparam logic [LW-1:0]    L_LAST = LW'(N_LANES - 1);
  localparam logic [ROW_W-1:0] R_LAST = ROW_W'(ROWS - 1);
  localparam logic [CA_W-1:0]  A_LAST = CA_W'(ROWS * K - 1);
  localparam logic [RA_W-1:0]  ROWS_A = RA_W'(ROWS);

  if (ACC_W < X_W + A_W + $clog2(K)) begin : g_acc_chk
    $error("mvm_engine: ACC_W too small for X_W+A_W+clog2(K)");
  end

  state_t           state;
  logic [KW-1:0]    ld_k;
  logic [LW-1:0]    ld_l;
  logic             start;
  logic             mode_q;

  logic             vld_p0;
  logic [KW-1:0]    k_cnt;
  logic [ROW_W-1:0] r_cnt;
  logic             vld_p1;
  logic [KW-1:0]    k_p1;
  logic [ROW_W-1:0] r_p1;
  logic             vld_p2;
  logic [ROW_W-1:0] wr_row_p2;
  logic [RW-1:0]    wr_data_p2;
  logic [RW-1:0]    sum_all;

  logic [X_W-1:0]   x_buf [K][N_LANES];
  logic [RW-1:0]    ram   [ROWS];
  logic [ROW_W-1:0] rd_row;

  assign rd_row = rd_addr[ROW_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_ready    <= 1'b0;
      xload_done <= 1'b0;
      busy       <= 1'b0;
      alu_done   <= 1'b0;
      start      <= 1'b0;
      mode_q     <= 1'b0;
      ld_k       <= '0;
      ld_l       <= '0;
    end else begin
      xload_done <= 1'b0;
      alu_done   <= 1'b0;
      start      <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            state   <= LOAD;
            x_ready <= 1'b1;
            busy    <= 1'b1;
            ld_k    <= '0;
            ld_l    <= '0;
          end
        end
        LOAD: begin
          if (x_valid) begin
            if (ld_l == L_LAST) begin
              ld_l <= '0;
              if (ld_k == K_LAST) begin
                state      <= LOADED;
                x_ready    <= 1'b0;
                busy       <= 1'b0;
                xload_done <= 1'b1;
              end else begin
                ld_k <= ld_k + 1'b1;
              end
            end else begin
              ld_l <= ld_l + 1'b1;
            end
          end
        end
        LOADED: begin
          if (load_en) begin
            state   <= LOAD;
            x_ready <= 1'b1;
            busy    <= 1'b1;
            ld_k    <= '0;
            ld_l    <= '0;
          end else if (alu_en) begin
            state  <= COMPUTE;
            busy   <= 1'b1;
            mode_q <= mode_signed;
            start  <= 1'b1;
          end
        end
        COMPUTE: begin
          if (vld_p2 && (wr_row_p2 == R_LAST)) begin
            state    <= LOADED;
            busy     <= 1'b0;
            alu_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == LOAD) && x_valid) x_buf[ld_k][ld_l] <= x_data;
  end

  // Stage p0: coefficient address issue, one per cycle, no bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      coef_addr <= '0;
      k_cnt     <= '0;
      r_cnt     <= '0;
      vld_p1    <= 1'b0;
      k_p1      <= '0;
      r_p1      <= '0;
      vld_p2    <= 1'b0;
      wr_row_p2 <= '0;
    end else begin
      if (start) begin
        vld_p0    <= 1'b1;
        coef_addr <= '0;
        k_cnt     <= '0;
        r_cnt     <= '0;
      end else if (vld_p0) begin
        if (coef_addr == A_LAST) begin
          vld_p0 <= 1'b0;
        end else begin
          coef_addr <= coef_addr + 1'b1;
          if (k_cnt == K_LAST) begin
            k_cnt <= '0;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
      end
      // Stage p1: ROM data arrives, lanes MAC
      vld_p1    <= vld_p0;
      k_p1      <= k_cnt;
      r_p1      <= r_cnt;
      // Stage p2: completed row waits one cycle in the write register
      vld_p2    <= vld_p1 && (k_p1 == K_LAST);
      wr_row_p2 <= r_p1;
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic signed [ACC_W-1:0] lane_sum;
    mvm_lane_mac #(.X_W(X_W), .A_W(A_W), .ACC_W(ACC_W)) u_mac (
      .clk         (clk),
      .en          (vld_p1),
      .first       (k_p1 == '0),
      .mode_signed (mode_q),
      .x           (x_buf[k_p1][l]),
      .a           (coef_data),
      .sum         (lane_sum)
    );
    assign sum_all[l*ACC_W +: ACC_W] = lane_sum;
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && (k_p1 == K_LAST)) wr_data_p2 <= sum_all;
  end

  always_ff @(posedge clk) begin
    if (vld_p2) ram[wr_row_p2] <= wr_data_p2;
  end

  // Registered read port; a read colliding with a write sees the old row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (rd_addr < ROWS_A) ? ram[rd_row] : '0;
    end
  end

endmodule

// File: tb/tb_mvm_engine.sv
// Directed bench for mvm_engine with a read-data scoreboard and a 1-cycle ROM model.
module tb_mvm_engine;

  localparam int RW = 72;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_en, x_valid, alu_en, mode_signed, rd_en;
  logic [7:0]    x_data;
  logic          x_ready, xload_done, busy, alu_done, rd_valid;
  logic [3:0]    coef_addr;
  logic [7:0]    coef_data;
  logic [2:0]    rd_addr;
  logic [RW-1:0] rd_data;

  logic [7:0]    xmem [16];
  logic [7:0]    rom  [16];
  logic [RW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) coef_data <= rom[coef_addr];

  mvm_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .x_valid     (x_valid),
    .x_data      (x_data),
    .x_ready     (x_ready),
    .xload_done  (xload_done),
    .alu_en      (alu_en),
    .mode_signed (mode_signed),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .busy        (busy),
    .alu_done    (alu_done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // X patterns: 0 -> k+l+1, 1 -> 0x80, 2 -> 0xFF, 3 -> 4k+l
  task automatic set_x(input int pat);
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) begin
        int idx;
        logic [7:0] v;
        idx = 4 * k + l;
        case (pat)
          0:       v = 8'(k + l + 1);
          1:       v = 8'h80;
          2:       v = 8'hFF;
          3:       v = 8'(4 * k + l);
          default: v = 8'h00;
        endcase
        xmem[idx[3:0]] = v;
      end
    end
  endtask

  // A patterns: 0 -> 1, 1 -> 0x80, 2 -> 0xFF, 3 -> 2, 4 -> identity, 5 -> r+1
  task automatic set_a(input int pat);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        logic [7:0] v;
        idx = 4 * r + k;
        case (pat)
          0:       v = 8'd1;
          1:       v = 8'h80;
          2:       v = 8'hFF;
          3:       v = 8'h02;
          4:       v = (r == k) ? 8'd1 : 8'd0;
          5:       v = 8'(r + 1);
          default: v = 8'h00;
        endcase
        rom[idx[3:0]] = v;
      end
    end
  endtask

  // Hand-derived row results per lane l for each scenario.
  function automatic logic [RW-1:0] exp_row(input int pat, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int l = 0; l < 4; l++) begin
      int e;
      case (pat)
        1:       e = 4 * l + 10;
        2:       e = 65536;
        3:       e = 260100;
        4:       e = -8;
        5:       e = 4 * r + l;
        6:       e = r + l + 1;
        7:       e = (r + 1) * (4 * l + 10);
        default: e = 0;
      endcase
      v[l*18 +: 18] = e[17:0];
    end
    return v;
  endfunction

  task automatic load_x(input bit start, input bit bp);
    int n, cyc, done_cnt;
    bit rdy;
    if (start) begin
      load_en = 1'b1;
      @(posedge clk); #1;
      load_en = 1'b0;
    end
    n = 0; cyc = 0; done_cnt = 0;
    while (n < 16 && cyc < 200) begin
      x_valid = bp ? (cyc % 2 == 0) : 1'b1;
      x_data  = xmem[n[3:0]];
      rdy     = x_ready;
      @(posedge clk); #1;
      if (x_valid && rdy) n++;
      if (xload_done) done_cnt++;
      cyc++;
    end
    x_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (xload_done) done_cnt++;
    end
    chk("x_transfers", n, 16);
    chk("xload_done_pulses", done_cnt, 1);
    chk("x_ready_after_load", x_ready, 1'b0);
  endtask

  task automatic compute(input bit sgn);
    int lat;
    mode_signed = sgn;
    alu_en = 1'b1;
    @(posedge clk); #1;
    alu_en = 1'b0;
    mode_signed = ~sgn;
    chk("busy_in_compute", busy, 1'b1);
    lat = 0;
    while (!alu_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("alu_done_latency", lat, 19);
    chk("busy_at_done", busy, 1'b0);
  endtask

  task automatic read_rows(input int pat);
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(exp_row(pat, r));
      rd_en = 1'b1;
      rd_addr = 3'(r);
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int bad, lat;
    load_en = 0; x_valid = 0; x_data = 0; alu_en = 0;
    mode_signed = 0; rd_en = 0; rd_addr = 0;
    fork
      forever begin
        @(negedge clk);
        if (rd_valid) begin
          if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
          else chk("rd_data", rd_data, exp_q.pop_front());
        end
      end
      begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    #2 rst_n = 1'b0;
    #20;
    chk("reset_ctrl", {x_ready, xload_done, busy, alu_done, rd_valid}, 5'b0);
    chk("reset_coef_addr", coef_addr, 4'd0);
    chk("reset_rd_data", rd_data, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // alu_en in IDLE is ignored
    alu_en = 1'b1;
    @(posedge clk); #1;
    alu_en = 1'b0;
    bad = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (busy || alu_done || x_ready) bad++;
    end
    chk("alu_en_in_idle", bad, 0);

    // Unsigned defaults
    set_x(0); set_a(0);
    load_x(1'b1, 1'b0);
    compute(1'b0);
    read_rows(1);

    // Signed / unsigned extremes
    set_x(1); set_a(1);
    load_x(1'b1, 1'b0);
    compute(1'b1);
    read_rows(2);
    set_x(2); set_a(2);
    load_x(1'b1, 1'b0);
    compute(1'b0);
    read_rows(3);
    set_a(3);
    compute(1'b1);
    read_rows(4);

    // Backpressure with an order-revealing X and identity A
    set_x(3); set_a(4);
    load_x(1'b1, 1'b1);
    compute(1'b0);
    read_rows(5);

    // load_en and alu_en together in LOADED
    set_x(0);
    load_en = 1'b1; alu_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; alu_en = 1'b0;
    chk("reload_x_ready", x_ready, 1'b1);
    chk("reload_busy", busy, 1'b1);
    bad = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (alu_done) bad++;
    end
    chk("compute_suppressed", bad, 0);
    load_x(1'b0, 1'b0);
    compute(1'b0);
    read_rows(6);

    // Reset in the middle of COMPUTE
    set_x(2); set_a(3);
    load_x(1'b1, 1'b0);
    mode_signed = 1'b0;
    alu_en = 1'b1;
    @(posedge clk); #1;
    alu_en = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {x_ready, xload_done, busy, alu_done, rd_valid}, 5'b0);
    chk("abort_coef_addr", coef_addr, 4'd0);
    chk("abort_rd_data", rd_data, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    set_x(0); set_a(5);
    load_x(1'b1, 1'b0);
    compute(1'b0);
    read_rows(7);

    // Reads while computing: collision returns old row, next cycle new row, out-of-range is zero
    set_x(3); set_a(4);
    load_x(1'b1, 1'b0);
    mode_signed = 1'b0;
    alu_en = 1'b1;
    @(posedge clk); #1;
    alu_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    exp_q.push_back(exp_row(7, 0));
    rd_en = 1'b1; rd_addr = 3'd0;
    @(posedge clk); #1;
    exp_q.push_back(exp_row(5, 0));
    @(posedge clk); #1;
    exp_q.push_back('0);
    rd_addr = 3'd5;
    @(posedge clk); #1;
    rd_en = 1'b0;
    lat = 0;
    while (!alu_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("alu_done_with_reads", alu_done, 1'b1);
    read_rows(5);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
